// File: rtl/tone_led_scheduler_pkg.sv
// tone_led_scheduler_pkg: scheduler states, jingle tone codes and the jingle tone table.
package tone_led_scheduler_pkg;
   typedef enum logic [2:0] {IDLE, PNOTE, PGAP, ECHO, JNOTE} state_t;
   localparam logic [2:0] TONE_J5 = 3'd5;
   localparam logic [2:0] TONE_J6 = 3'd6;
   localparam logic [2:0] TONE_J7 = 3'd7;
   localparam logic [1:0] JNOTE_LAST = 2'd2;
   // Win climbs 5,6,7 and lose falls 7,6,5; the unused slot stays inside the table.
   function automatic logic [2:0] jingle_tone(input logic win, input logic [1:0] idx);
      case ({win, idx})
         3'b100: return TONE_J5;
         3'b101: return TONE_J6;
         3'b110: return TONE_J7;
         3'b000: return TONE_J7;
         3'b001: return TONE_J6;
         3'b010: return TONE_J5;
         default: return TONE_J5;
      endcase
   endfunction
endpackage

// File: rtl/tone_led_scheduler_cycle_timer.sv
// tone_led_scheduler_cycle_timer: loadable down-counter that holds at zero and flags it.
module tone_led_scheduler_cycle_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] cnt;
   assign zero = cnt == '0;
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && !zero) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/tone_led_scheduler.sv
// tone_led_scheduler: arbitrates playback notes, button echo and jingles onto the buzzer and colour LED.
module tone_led_scheduler
   import tone_led_scheduler_pkg::*;
#(
   parameter int NOTE_CYCLES  = 75_000_000,
   parameter int GAP_CYCLES   = 25_000_000,
   parameter int JNOTE_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play_req,
   input  logic [1:0] play_color,
   input  logic       echo_req,
   input  logic [1:0] echo_color,
   input  logic       jingle_start,
   input  logic       jingle_win,
   output logic [2:0] tone,
   output logic       buzzer_en,
   output logic [2:0] cor,
   output logic       led_en,
   output logic       play_done,
   output logic       play_abort,
   output logic       jingle_done,
   output logic       busy
);
   localparam int MAXC = NOTE_CYCLES > GAP_CYCLES ?
      (NOTE_CYCLES > JNOTE_CYCLES ? NOTE_CYCLES : JNOTE_CYCLES) :
      (GAP_CYCLES > JNOTE_CYCLES ? GAP_CYCLES : JNOTE_CYCLES);
   localparam int TW = MAXC > 1 ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] NOTE_LD  = TW'(NOTE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] JNOTE_LD = TW'(JNOTE_CYCLES - 1);

   state_t state, nxt;
   logic [1:0] col, nxt_col, idx, nxt_idx;
   logic win, nxt_win, load, zero;
   logic [TW-1:0] load_val;
   logic [2:0] tone_n, cor_n;
   logic buz_n, led_n, done_n, abort_n, jdone_n;

   tone_led_scheduler_cycle_timer #(.W(TW)) timer (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_val(load_val),
      .en(state inside {PNOTE, PGAP, JNOTE}),
      .zero(zero)
   );

   // Outputs are registered from the next-state decode so they track the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         col <= '0;
         idx <= '0;
         win <= 1'b0;
         tone <= '0;
         buzzer_en <= 1'b0;
         cor <= '0;
         led_en <= 1'b0;
         play_done <= 1'b0;
         play_abort <= 1'b0;
         jingle_done <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= nxt;
         col <= nxt_col;
         idx <= nxt_idx;
         win <= nxt_win;
         tone <= tone_n;
         buzzer_en <= buz_n;
         cor <= cor_n;
         led_en <= led_n;
         play_done <= done_n;
         play_abort <= abort_n;
         jingle_done <= jdone_n;
         busy <= nxt != IDLE;
      end
   end

   always_comb begin
      nxt = state;
      nxt_col = col;
      nxt_idx = idx;
      nxt_win = win;
      load = 1'b0;
      load_val = '0;
      if (jingle_start && state != JNOTE) begin
         nxt = JNOTE;
         nxt_idx = '0;
         nxt_win = jingle_win;
         load = 1'b1;
         load_val = JNOTE_LD;
      end else begin
         case (state)
            IDLE:
               if (echo_req) begin
                  nxt = ECHO;
                  nxt_col = echo_color;
               end else if (play_req) begin
                  nxt = PNOTE;
                  nxt_col = play_color;
                  load = 1'b1;
                  load_val = NOTE_LD;
               end
            PNOTE:
               if (zero) begin
                  nxt = PGAP;
                  load = 1'b1;
                  load_val = GAP_LD;
               end
            PGAP: if (zero) nxt = IDLE;
            ECHO: if (!echo_req) nxt = IDLE;
            JNOTE:
               if (zero) begin
                  if (idx == JNOTE_LAST) nxt = IDLE;
                  else begin
                     nxt_idx = idx + 1'b1;
                     load = 1'b1;
                     load_val = JNOTE_LD;
                  end
               end
            default: nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      buz_n = nxt inside {PNOTE, ECHO, JNOTE};
      led_n = nxt inside {PNOTE, ECHO};
      tone_n = nxt == JNOTE ? jingle_tone(nxt_win, nxt_idx) : led_n ? {1'b0, nxt_col} : 3'd0;
      cor_n = led_n ? {1'b0, nxt_col} : 3'd0;
      done_n = state == PGAP && zero && !jingle_start;
      jdone_n = state == JNOTE && zero && idx == JNOTE_LAST;
      abort_n = (play_req && (state != IDLE || echo_req || jingle_start)) ||
                (jingle_start && state inside {PNOTE, PGAP});
   end
endmodule

// File: tb/tb_tone_led_scheduler.sv
// tb_tone_led_scheduler: directed vector table plus hand-written latency and reset-mid-jingle sequences.
module tb_tone_led_scheduler;
   logic clk = 1'b0, reset = 1'b1;
   logic play_req = 1'b0, echo_req = 1'b0, jingle_start = 1'b0, jingle_win = 1'b0;
   logic [1:0] play_color = '0, echo_color = '0;
   logic [2:0] tone, cor;
   logic buzzer_en, led_en, play_done, play_abort, jingle_done, busy;
   logic [11:0] act;
   int checks = 0, errors = 0;

   typedef struct {
      int n;
      logic rst, pr, er, js, jw;
      logic [1:0] pc, ec;
      logic [11:0] e;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   tone_led_scheduler #(.NOTE_CYCLES(8), .GAP_CYCLES(4), .JNOTE_CYCLES(6)) dut (
      .clk(clk),
      .reset(reset),
      .play_req(play_req),
      .play_color(play_color),
      .echo_req(echo_req),
      .echo_color(echo_color),
      .jingle_start(jingle_start),
      .jingle_win(jingle_win),
      .tone(tone),
      .buzzer_en(buzzer_en),
      .cor(cor),
      .led_en(led_en),
      .play_done(play_done),
      .play_abort(play_abort),
      .jingle_done(jingle_done),
      .busy(busy)
   );

   assign act = {tone, buzzer_en, cor, led_en, play_done, play_abort, jingle_done, busy};

   function automatic logic [11:0] ex(input int t, b, c, l, pd, pa, jd, bz);
      return {t[2:0], b[0], c[2:0], l[0], pd[0], pa[0], jd[0], bz[0]};
   endfunction
   function automatic logic [11:0] on(input int c);
      return ex(c, 1, c, 1, 0, 0, 0, 1);
   endfunction
   function automatic logic [11:0] jn(input int t);
      return ex(t, 1, 0, 0, 0, 0, 0, 1);
   endfunction

   task automatic add(input int n, r, pr, pc, er, ec, js, jw, input logic [11:0] e);
      vec_t v;
      v.n = n;
      v.rst = r[0];
      v.pr = pr[0];
      v.pc = pc[1:0];
      v.er = er[0];
      v.ec = ec[1:0];
      v.js = js[0];
      v.jw = jw[0];
      v.e = e;
      vecs.push_back(v);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [11:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end
   endtask

   initial begin
      int lat, jd_seen, waited;
      logic [11:0] z, gap, pd, jd;
      z = ex(0, 0, 0, 0, 0, 0, 0, 0);
      gap = ex(0, 0, 0, 0, 0, 0, 0, 1);
      pd = ex(0, 0, 0, 0, 1, 0, 0, 0);
      jd = ex(0, 0, 0, 0, 0, 0, 1, 0);
      //  n  r pr pc er ec js jw  expected
      add(2, 1, 0, 0, 0, 0, 0, 0, z);
      add(2, 0, 0, 0, 0, 0, 0, 0, z);
      add(1, 0, 1, 2, 0, 0, 0, 0, on(2));
      add(7, 0, 0, 0, 0, 0, 0, 0, on(2));
      add(4, 0, 0, 0, 0, 0, 0, 0, gap);
      add(1, 0, 0, 0, 0, 0, 0, 0, pd);
      add(1, 0, 0, 0, 0, 0, 0, 0, z);
      // win jingle
      add(1, 0, 0, 0, 0, 0, 1, 1, jn(5));
      add(5, 0, 0, 0, 0, 0, 0, 0, jn(5));
      add(6, 0, 0, 0, 0, 0, 0, 0, jn(6));
      add(6, 0, 0, 0, 0, 0, 0, 0, jn(7));
      add(1, 0, 0, 0, 0, 0, 0, 0, jd);
      // lose jingle pre-empts a note in its 3rd cycle; busy play_req dropped; restart ignored
      add(1, 0, 1, 1, 0, 0, 0, 0, on(1));
      add(2, 0, 0, 0, 0, 0, 0, 0, on(1));
      add(1, 0, 0, 0, 0, 0, 1, 0, ex(7, 1, 0, 0, 0, 1, 0, 1));
      add(1, 0, 1, 3, 0, 0, 0, 0, ex(7, 1, 0, 0, 0, 1, 0, 1));
      add(4, 0, 0, 0, 0, 0, 0, 0, jn(7));
      add(1, 0, 0, 0, 0, 0, 1, 1, jn(6));
      add(5, 0, 0, 0, 0, 0, 0, 0, jn(6));
      add(6, 0, 0, 0, 0, 0, 0, 0, jn(5));
      add(1, 0, 0, 0, 0, 0, 0, 0, jd);
      // echo hold
      add(20, 0, 0, 0, 1, 1, 0, 0, on(1));
      add(1, 0, 0, 0, 0, 0, 0, 0, z);
      // all three requests at once, echo still held afterwards
      add(1, 0, 1, 3, 1, 2, 1, 1, ex(5, 1, 0, 0, 0, 1, 0, 1));
      add(5, 0, 0, 0, 1, 2, 0, 0, jn(5));
      add(6, 0, 0, 0, 1, 2, 0, 0, jn(6));
      add(6, 0, 0, 0, 1, 2, 0, 0, jn(7));
      add(1, 0, 0, 0, 1, 2, 0, 0, jd);
      add(1, 0, 0, 0, 1, 2, 0, 0, on(2));
      add(1, 0, 0, 0, 0, 0, 0, 0, z);
      // echo is held off by playback and granted afterwards
      add(1, 0, 1, 0, 0, 0, 0, 0, on(0));
      add(7, 0, 0, 0, 1, 3, 0, 0, on(0));
      add(4, 0, 0, 0, 1, 3, 0, 0, gap);
      add(1, 0, 0, 0, 1, 3, 0, 0, pd);
      add(1, 0, 0, 0, 1, 3, 0, 0, on(3));
      add(1, 0, 0, 0, 0, 0, 0, 0, z);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst;
         play_req = vecs[i].pr;
         play_color = vecs[i].pc;
         echo_req = vecs[i].er;
         echo_color = vecs[i].ec;
         jingle_start = vecs[i].js;
         jingle_win = vecs[i].jw;
         for (int k = 0; k < vecs[i].n; k++) begin
            tick;
            check($sformatf("vec%0d.%0d", i, k), vecs[i].e);
         end
      end
      reset = 1'b0;
      play_req = 1'b0;
      echo_req = 1'b0;
      jingle_start = 1'b0;

      // request-to-done latency: 8 note + 4 gap cycles after the accepting edge
      play_req = 1'b1;
      play_color = 2'd3;
      tick;
      play_req = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         tick;
         if (play_done) begin
            lat = k;
            break;
         end
      end
      checks++;
      if (lat != 12) begin
         errors++;
         $display("FAIL play_done_latency: got %0d expected 12", lat);
      end

      // reset during the second jingle note
      tick;
      jingle_start = 1'b1;
      jingle_win = 1'b1;
      tick;
      jingle_start = 1'b0;
      waited = 0;
      while (tone !== 3'd6 && waited < 20) begin
         tick;
         waited++;
      end
      checks++;
      if (waited >= 20) begin
         errors++;
         $display("FAIL reach_jnote1: got tone %0d expected 6 within 20 cycles", tone);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("reset_mid_jingle", z);
      jd_seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick;
         if (jingle_done) jd_seen++;
      end
      checks++;
      if (jd_seen != 0) begin
         errors++;
         $display("FAIL no_jingle_done_after_reset: got %0d pulses expected 0", jd_seen);
      end
      check("idle_after_reset", z);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
